// File: rtl/write_fifo.sv
// Packs narrow words LSB-first into wide lines and queues completed lines in a
// small first-word-fall-through line FIFO. Optional flush port: WRITE_FIFO_FLUSH_EN.
module write_fifo #(
  parameter int LINE_WIDTH = 32,
  parameter int WORD_WIDTH = 8,
  parameter int NUM_LINES  = 4,
  parameter int PTR_BITS   = $clog2(NUM_LINES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  wr,
  output logic                  full,
  input  logic                  rd,
  output logic                  empty,
  output logic [LINE_WIDTH-1:0] line_out,
  output logic [PTR_BITS:0]     count,
  output logic                  partial
`ifdef WRITE_FIFO_FLUSH_EN
  ,
  input  logic                  flush
`endif
);

  localparam int WORDS_PER_LINE = LINE_WIDTH / WORD_WIDTH;
  localparam int WCNT_BITS      = $clog2(WORDS_PER_LINE);
  localparam logic [WCNT_BITS-1:0] LAST_WORD = WCNT_BITS'(WORDS_PER_LINE - 1);

  // Handshake: a word is taken on a rising edge where wr && !full; the head line
  // is popped on a rising edge where rd && !empty. full and empty depend only on
  // registered state, so a pop never unblocks a write in the same cycle.

  logic [LINE_WIDTH-1:0] asm_q;
  logic [LINE_WIDTH-1:0] asm_ins;
  logic [WCNT_BITS-1:0]  word_cnt;
  logic [PTR_BITS:0]     head;
  logic [PTR_BITS:0]     base;
  logic [LINE_WIDTH-1:0] lines [NUM_LINES];

  logic lines_full;
  logic last_word;
  logic accept;
  logic pop;
  logic commit;
  logic flush_commit;

  assign lines_full = (head[PTR_BITS-1:0] == base[PTR_BITS-1:0]) &&
                      (head[PTR_BITS] != base[PTR_BITS]);
  assign empty      = (head == base);
  assign count      = head - base;
  assign last_word  = (word_cnt == LAST_WORD);
  assign full       = lines_full && last_word;
  assign partial    = (word_cnt != '0);
  assign accept     = wr && !full;
  assign pop        = rd && !empty;
  assign line_out   = empty ? '0 : lines[base[PTR_BITS-1:0]];

  // Assembly register with the incoming word already merged into its slot.
  always_comb begin
    asm_ins = asm_q;
    for (int i = 0; i < WORDS_PER_LINE; i++) begin
      if (accept && (word_cnt == WCNT_BITS'(i))) begin
        asm_ins[i*WORD_WIDTH +: WORD_WIDTH] = word_in;
      end
    end
  end

`ifdef WRITE_FIFO_FLUSH_EN
  // Flush commits whatever is assembled (including a same-cycle word); slots
  // never written stay zero because asm_q is cleared after every commit.
  assign flush_commit = flush && !lines_full && (partial || accept);
`else
  assign flush_commit = 1'b0;
`endif

  assign commit = (accept && last_word) || flush_commit;

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_q    <= '0;
      word_cnt <= '0;
      head     <= '0;
      base     <= '0;
    end else begin
      if (commit) begin
        asm_q    <= '0;
        word_cnt <= '0;
        head     <= head + 1'b1;
      end else if (accept) begin
        asm_q    <= asm_ins;
        word_cnt <= word_cnt + 1'b1;
      end
      if (pop) begin
        base <= base + 1'b1;
      end
    end
  end

  // Line storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (!rst && commit) begin
      lines[head[PTR_BITS-1:0]] <= asm_ins;
    end
  end

endmodule

// File: tb/tb_write_fifo.sv
// Bench for write_fifo: directed scenarios plus random traffic, checked against
// a queue-based reference model and a scoreboard of expected popped lines.
module tb_write_fifo;

  localparam int LW  = 32;
  localparam int WW  = 8;
  localparam int NL  = 4;
  localparam int PB  = 2;
  localparam int WPL = LW / WW;

  logic          clk = 1'b0;
  logic          rst;
  logic [WW-1:0] word_in;
  logic          wr;
  logic          rd;
  logic          flush;
  logic          full;
  logic          empty;
  logic [LW-1:0] line_out;
  logic [PB:0]   count;
  logic          partial;

  always #5 clk = ~clk;

  write_fifo #(
    .LINE_WIDTH(LW),
    .WORD_WIDTH(WW),
    .NUM_LINES (NL),
    .PTR_BITS  (PB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .word_in (word_in),
    .wr      (wr),
    .full    (full),
    .rd      (rd),
    .empty   (empty),
    .line_out(line_out),
    .count   (count),
    .partial (partial)
`ifdef WRITE_FIFO_FLUSH_EN
    ,
    .flush   (flush)
`endif
  );

  int checks   = 0;
  int failures = 0;
  bit started  = 0;

  logic [LW-1:0] exp_q[$];
  logic [LW-1:0] m_lines[$];
  logic [WW-1:0] m_words[$];

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit m_full();
    return (m_lines.size() == NL) && (m_words.size() == WPL - 1);
  endfunction

  // Build a line from the collected words: word i occupies bits [i*WW +: WW].
  function automatic logic [LW-1:0] pack_words(input logic [WW-1:0] w[$]);
    logic [LW-1:0] l;
    l = '0;
    for (int i = 0; i < w.size(); i++) l = l | (LW'(w[i]) << (i * WW));
    return l;
  endfunction

  task automatic m_commit();
    logic [LW-1:0] l;
    l = pack_words(m_words);
    m_lines.push_back(l);
    exp_q.push_back(l);
    m_words.delete();
  endtask

  // Reference model: updates on each rising edge from the inputs driven before it.
  always @(posedge clk) begin
    bit lf;
    bit acc;
    lf  = (m_lines.size() == NL);
    acc = wr && !m_full();
    if (rst) begin
      m_lines.delete();
      m_words.delete();
      exp_q.delete();
      started = 1;
    end else begin
      if (rd && m_lines.size() != 0) void'(m_lines.pop_front());
      if (acc) begin
        m_words.push_back(word_in);
        if (m_words.size() == WPL) m_commit();
      end
`ifdef WRITE_FIFO_FLUSH_EN
      if (flush && !lf && m_words.size() != 0) m_commit();
`endif
    end
  end

  // Monitor: compares status every cycle and pops the scoreboard on each DUT pop.
  always @(negedge clk) begin
    if (started) begin
      check("empty", LW'(empty), LW'(m_lines.size() == 0));
      check("count", LW'(count), LW'(m_lines.size()));
      check("full", LW'(full), LW'(m_full()));
      check("partial", LW'(partial), LW'(m_words.size() != 0));
      check("line_out", line_out, (m_lines.size() != 0) ? m_lines[0] : '0);
      if (!rst && rd && !empty) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_underflow: got line %h expected no line (t=%0t)", line_out, $time);
        end else begin
          check("pop_data", line_out, exp_q.pop_front());
        end
      end
    end
  end

  task automatic drive(input logic w, input logic [WW-1:0] d, input logic r);
    wr      = w;
    word_in = d;
    rd      = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    int  idx;
    bit  saw_full;
    rst     = 1'b1;
    wr      = 1'b0;
    rd      = 1'b0;
    flush   = 1'b0;
    word_in = '0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_empty", LW'(empty), 1);
    check("rst_count", LW'(count), 0);
    check("rst_full", LW'(full), 0);
    check("rst_partial", LW'(partial), 0);
    check("rst_line_out", line_out, 0);

    // First line, LSB word first.
    drive(1'b1, 8'h11, 1'b0);
    drive(1'b1, 8'h22, 1'b0);
    drive(1'b1, 8'h33, 1'b0);
    drive(1'b1, 8'h44, 1'b0);
    check("t1_empty", LW'(empty), 0);
    check("t1_count", LW'(count), 1);
    check("t1_line", line_out, 32'h44332211);
    check("t1_partial", LW'(partial), 0);
    drive(1'b0, '0, 1'b1);
    check("t1_pop_count", LW'(count), 0);

    // Fill storage, then block only the line-completing word.
    for (int i = 0; i < 16; i++) drive(1'b1, WW'(i), 1'b0);
    check("t2_count4", LW'(count), 4);
    check("t2_full0", LW'(full), 0);
    drive(1'b1, 8'hA0, 1'b0);
    drive(1'b1, 8'hA1, 1'b0);
    drive(1'b1, 8'hA2, 1'b0);
    check("t2_partial", LW'(partial), 1);
    check("t2_full1", LW'(full), 1);
    drive(1'b1, 8'h99, 1'b0);
    drive(1'b1, 8'h99, 1'b0);
    check("t2_drop_count", LW'(count), 4);
    check("t2_drop_partial", LW'(partial), 1);
    drive(1'b1, 8'h99, 1'b1);
    check("t2_after_pop_full", LW'(full), 0);
    check("t2_after_pop_count", LW'(count), 3);
    drive(1'b1, 8'h99, 1'b0);
    check("t2_accept_count", LW'(count), 4);
    check("t2_accept_partial", LW'(partial), 0);
    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b1);
    check("t2_tail_line", line_out, 32'h99A2A1A0);
    drive(1'b0, '0, 1'b1);
    check("t2_drained", LW'(empty), 1);

    // Pop while empty, then one line in and out.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b1);
      check("t3_empty", LW'(empty), 1);
      check("t3_count", LW'(count), 0);
      check("t3_line", line_out, 0);
    end
    for (int i = 5; i < 9; i++) drive(1'b1, WW'(i), 1'b0);
    check("t3_count1", LW'(count), 1);
    drive(1'b0, '0, 1'b1);
    check("t3_count0", LW'(count), 0);

    // Commit and pop in the same cycle with one line stored.
    for (int i = 0; i < 4; i++) drive(1'b1, WW'(8'h10 + i), 1'b0);
    drive(1'b1, 8'h20, 1'b0);
    drive(1'b1, 8'h21, 1'b0);
    drive(1'b1, 8'h22, 1'b0);
    drive(1'b1, 8'h23, 1'b1);
    check("t4_count", LW'(count), 1);
    check("t4_empty", LW'(empty), 0);
    check("t4_line", line_out, 32'h23222120);
    drive(1'b0, '0, 1'b1);

    // Stream 40 words with eager reads; pointers wrap.
    idx      = 0;
    saw_full = 0;
    for (int c = 0; c < 200 && (idx < 40 || !empty); c++) begin
      if (full) saw_full = 1;
      drive(idx < 40, WW'(idx), !empty);
      if (idx < 40) idx++;
    end
    check("t5_no_full", LW'(saw_full), 0);
    check("t5_drained", LW'(empty), 1);
    check("t5_all_words", LW'(idx), 40);

    // Reset mid-line discards the partial line.
    drive(1'b1, 8'hAA, 1'b0);
    drive(1'b1, 8'hBB, 1'b0);
    do_reset();
    check("t6_partial", LW'(partial), 0);
    check("t6_count", LW'(count), 0);
    for (int i = 1; i < 5; i++) drive(1'b1, WW'(i), 1'b0);
    check("t6_line", line_out, 32'h04030201);
    drive(1'b0, '0, 1'b1);

`ifdef WRITE_FIFO_FLUSH_EN
    drive(1'b1, 8'hAA, 1'b0);
    drive(1'b1, 8'hBB, 1'b0);
    flush = 1'b1;
    drive(1'b0, '0, 1'b0);
    flush = 1'b0;
    check("t7_flush_line", line_out, 32'h0000BBAA);
    check("t7_flush_partial", LW'(partial), 0);
    check("t7_flush_count", LW'(count), 1);
    drive(1'b0, '0, 1'b1);
`endif

    // Random traffic with occasional resets.
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 79) == 0);
`ifdef WRITE_FIFO_FLUSH_EN
      flush = ($urandom_range(0, 7) == 0);
`endif
      drive($urandom_range(0, 3) != 0, WW'($urandom_range(0, 255)), $urandom_range(0, 2) == 0);
    end
    rst   = 1'b0;
    flush = 1'b0;
    for (int c = 0; c < 10; c++) drive(1'b0, '0, 1'b1);
    check("final_empty", LW'(empty), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/write_fifo.md
Name: write_fifo

Overview:
- Packs a stream of narrow words into wide lines and queues the completed lines in a small line FIFO, LSB-word first.
- It is the packing counterpart of the line-to-word unpacking read path: word 0 of a line lands in bits [WORD_WIDTH-1:0], so unpacking a line reproduces the original word order.
- Sits between pixel/word producers and a line-wide consumer such as a memory writer or a line buffer.
- Single clock domain (clk).

Parameters:
- LINE_WIDTH, 32, width of one packed line; must be an integer multiple of WORD_WIDTH.
- WORD_WIDTH, 8, width of one input word.
- NUM_LINES, 4, line storage depth; power of 2, minimum 2.
- WORDS_PER_LINE, LINE_WIDTH/WORD_WIDTH (localparam), words per line; minimum 2.
- PTR_BITS, $clog2(NUM_LINES), line pointer index width.

Ports:
- clk  in  1  clock, all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- word_in  in  WORD_WIDTH  input word.
- wr  in  1  write strobe; the word is accepted when wr && !full.
- full  out  1  next word cannot be accepted.
- rd  in  1  pop the head line; ignored when empty.
- empty  out  1  no complete line stored.
- line_out  out  LINE_WIDTH  head line (first-word fall-through); 0 when empty.
- count  out  PTR_BITS+1  number of complete lines stored, 0..NUM_LINES.
- partial  out  1  assembly register holds 1..WORDS_PER_LINE-1 words.

Behaviour:
- State:
  - assembly register asm[LINE_WIDTH-1:0];
  - word_cnt, 0..WORDS_PER_LINE-1;
  - line array [0:NUM_LINES-1];
  - head and base pointers, each PTR_BITS+1 bits, MSB used as the wrap bit.
- Reset (sync): asm=0, word_cnt=0, head=base=0. Outputs: empty=1, full=0, count=0, partial=0, line_out=0. Storage contents are not cleared.
- lines_full = (head[PTR_BITS-1:0]==base[PTR_BITS-1:0]) && (head[PTR_BITS]!=base[PTR_BITS]).
- empty = (head==base). count = head-base, modulo 2^(PTR_BITS+1).
- full = lines_full && (word_cnt==WORDS_PER_LINE-1).
  - Words continue to accumulate while storage is full; only the line-completing word is blocked.
- full and empty are combinational from registered state only; there is no rd->full bypass.
  - A pop in cycle N allows a blocked write no earlier than cycle N+1.
- Accepted word, not the last word: asm slice [word_cnt*WORD_WIDTH +: WORD_WIDTH] <= word_in; word_cnt <= word_cnt+1.
- Accepted word, last word (word_cnt==WORDS_PER_LINE-1):
  - array[head[PTR_BITS-1:0]] <= {word_in, asm[LINE_WIDTH-WORD_WIDTH-1:0]};
  - head <= head+1; word_cnt <= 0; asm <= 0.
  - Latency: the line is visible on line_out / empty / count in the cycle after the last word is accepted.
- rd && !empty: base <= base+1. line_out shows the next line, or 0, in the following cycle.
- rd && empty: no state change.
- Simultaneous line commit and pop: both take effect; count is unchanged.
  - If count was 1, line_out switches to the new line in the next cycle and empty stays 0.
- wr while full: the word is dropped; no state change.
- Pointers wrap naturally modulo 2^(PTR_BITS+1); line order is preserved across wrap.
- partial = (word_cnt!=0).
- Reset mid-line discards the partial line and all stored lines.

Optional Feature:
- Macro: WRITE_FIFO_FLUSH_EN.
- With the macro defined:
  - Adds input port flush (1 bit).
  - When flush && partial && !lines_full, the partial line is committed to head, unfilled upper slices zero, word_cnt <= 0, head <= head+1.
  - flush with a same-cycle accepted word: the word is inserted first, then committed. If that word completes the line, a normal single commit occurs.
  - flush with word_cnt==0 and no word accepted: no effect.
  - flush while lines_full: ignored; the caller re-asserts it.
- Without the macro: no flush port; a partial line persists until completed or reset.

Test Plan:
- Reset, then write 0x11,0x22,0x33,0x44 on consecutive cycles -> the next cycle shows empty=0, count=1, line_out=0x44332211, partial=0.
- Write 16 words with no rd -> count=4, full=0. Write 3 more -> accepted, partial=1, full=1. Hold wr with 0x99 -> dropped. Pulse rd -> next cycle full=0; the 0x99 write is then accepted and becomes line 4's top byte.
- rd while empty after reset -> count=0, empty=1, line_out=0 throughout. Then commit a line and pop it with rd -> count 1->0.
- count=1 with a line commit and rd in the same cycle -> count stays 1, line_out changes to the new line, empty never rises.
- Stream 40 words (10 lines, data=index) with rd popping whenever !empty -> lines 0x03020100..0x27262524 are read in order, pointers wrap twice, and full never asserts.
- Write 0xAA,0xBB, then assert rst -> partial=0, count=0. Then write 0x01..0x04 -> line 0x04030201. With WRITE_FIFO_FLUSH_EN: write 0xAA,0xBB, flush -> next cycle line_out=0x0000BBAA, partial=0.
